// File: rtl/rr_burst_arbiter_if.sv
// rr_burst_arbiter_if: requester/downstream bundle for rr_burst_arbiter; adds io_pkt_count when RR_ARB_GRANT_STATS_EN is defined
interface rr_burst_arbiter_if #(parameter int N = 4, parameter int W = 32);
  localparam int PW = $clog2(N);
  logic [N-1:0] io_in_valid;
  logic [N-1:0] io_in_ready;
  logic [N-1:0] io_in_last;
  logic [N*W-1:0] io_in_bits;
  logic io_out_valid;
  logic io_out_ready;
  logic io_out_last;
  logic [W-1:0] io_out_bits;
  logic [PW-1:0] io_chosen;
  logic io_locked;
`ifdef RR_ARB_GRANT_STATS_EN
  logic [N*16-1:0] io_pkt_count;
`endif
  modport master (
`ifdef RR_ARB_GRANT_STATS_EN
    input io_pkt_count,
`endif
    output io_in_valid, io_in_bits, io_in_last, io_out_ready,
    input io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen, io_locked
  );
  modport slave (
`ifdef RR_ARB_GRANT_STATS_EN
    output io_pkt_count,
`endif
    input io_in_valid, io_in_bits, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen, io_locked
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter holding the grant for a whole packet; RR_ARB_GRANT_STATS_EN adds per-requester packet counters
module rr_burst_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input logic clock,
  input logic reset,
  rr_burst_arbiter_if.slave io
);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [N-1:0] w_rot;
  logic [PW-1:0] w_off;
  logic [PW:0] w_sum;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_chosen;
  logic w_valid;
  logic w_last;
  logic w_fire;
  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction
  // rotate valids so ptr sits at bit 0, find the lowest set bit, then rotate the offset back
  always_comb begin
    w_rot = N'({io.io_in_valid, io.io_in_valid} >> r_ptr);
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) w_off = w_rot[k] ? PW'(k) : w_off;
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick = ~|io.io_in_valid ? r_ptr : (w_sum >= (PW + 1)'(N)) ? PW'(w_sum - (PW + 1)'(N)) : PW'(w_sum);
    w_chosen = (r_state == LOCKED) ? r_owner : w_pick;
  end
  // pass-through datapath; every output is held at zero during reset
  always_comb begin
    w_valid = io.io_in_valid[w_chosen];
    w_last = io.io_in_last[w_chosen];
    w_fire = !reset && w_valid && io.io_out_ready;
    io.io_out_valid = !reset && w_valid;
    io.io_out_last = !reset && w_last;
    io.io_out_bits = reset ? '0 : io.io_in_bits[w_chosen * W +: W];
    io.io_chosen = reset ? '0 : w_chosen;
    io.io_locked = !reset && (r_state == LOCKED);
    io.io_in_ready = '0;
    for (int i = 0; i < N; i++) io.io_in_ready[i] = !reset && io.io_out_ready && (w_chosen == PW'(i));
  end
  // grant state: lock on a non-final beat, release and advance ptr past the winner on the final beat
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_owner <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_state <= IDLE;
        r_ptr <= inc_wrap(w_chosen);
      end else begin
        r_state <= LOCKED;
        r_owner <= w_chosen;
      end
    end
  end
`ifdef RR_ARB_GRANT_STATS_EN
  logic [N*16-1:0] r_cnt;
  // saturating count of completed packets per requester
  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else if (w_fire && w_last && r_cnt[w_chosen * 16 +: 16] != 16'hFFFF) r_cnt[w_chosen * 16 +: 16] <= r_cnt[w_chosen * 16 +: 16] + 16'd1;
  end
  // counters read as zero while reset is held
  always_comb io.io_pkt_count = reset ? '0 : r_cnt;
`endif
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: directed and randomized checks of rr_burst_arbiter against a packet-level reference model
module tb_rr_burst_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int PW = $clog2(N);
  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] vld;
  logic [N-1:0] lst;
  logic [N*W-1:0] bits;
  logic rdy;
  int n_checks = 0;
  int n_fail = 0;
  bit m_locked;
  int m_ptr;
  int m_owner;
  int m_cnt [N];
  rr_burst_arbiter_if #(.N(N), .W(W)) bus ();
  rr_burst_arbiter #(.N(N), .W(W)) dut (.clock(clock), .reset(reset), .io(bus));
  assign bus.io_in_valid = vld;
  assign bus.io_in_last = lst;
  assign bus.io_in_bits = bits;
  assign bus.io_out_ready = rdy;
  always #5 clock = ~clock;

  function automatic int exp_chosen();
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return m_ptr;
  endfunction

  task automatic adv();
    int c;
    c = exp_chosen();
    if (reset) begin
      m_locked = 0;
      m_ptr = 0;
      m_owner = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (vld[c] && rdy) begin
      if (lst[c]) begin
        m_locked = 0;
        m_ptr = (c + 1) % N;
        if (m_cnt[c] < 65535) m_cnt[c]++;
      end else begin
        m_locked = 1;
        m_owner = c;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1;
    vld = 4'b1111;
    lst = 4'b0000;
    rdy = 1;
    bits = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.io_chosen, bus.io_out_valid, bus.io_in_ready, bus.io_locked, bus.io_out_last, bus.io_out_bits} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ready=%b valid=%b locked=%b chosen=%0d bits=%h exp all zero", bus.io_in_ready, bus.io_out_valid, bus.io_locked, bus.io_chosen, bus.io_out_bits);
    end
    adv();
    reset = 0;
    vld = '0;
    #1;
    n_checks++;
    if (bus.io_locked !== 1'b0 || bus.io_chosen !== PW'(0) || bus.io_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got locked=%b chosen=%0d valid=%b exp 0 0 0", bus.io_locked, bus.io_chosen, bus.io_out_valid);
    end
    adv();
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    vld = 4'b1111;
    lst = 4'b1111;
    rdy = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (bus.io_chosen !== PW'(seq[k]) || bus.io_in_ready !== N'(1) << seq[k]) begin
        n_fail++;
        $display("FAIL round_robin step %0d got chosen=%0d ready=%b exp chosen=%0d", k, bus.io_chosen, bus.io_in_ready, seq[k]);
      end
      adv();
    end
  endtask

  task automatic test_burst();
    bit lk [3] = '{0, 1, 1};
    vld = 4'b0111;
    rdy = 1;
    for (int b = 0; b < 3; b++) begin
      lst = (b == 2) ? 4'b1111 : 4'b1101;
      #1;
      n_checks++;
      if (bus.io_chosen !== PW'(1) || bus.io_locked !== lk[b] || bus.io_out_last !== (b == 2)) begin
        n_fail++;
        $display("FAIL burst beat %0d got chosen=%0d locked=%b last=%b exp chosen=1 locked=%b", b, bus.io_chosen, bus.io_locked, bus.io_out_last, lk[b]);
      end
      adv();
    end
    #1;
    n_checks++;
    if (bus.io_chosen !== PW'(2) || bus.io_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_next got chosen=%0d locked=%b exp chosen=2 locked=0", bus.io_chosen, bus.io_locked);
    end
  endtask

  task automatic test_drop();
    vld = 4'b0101;
    lst = 4'b0000;
    rdy = 1;
    adv();
    vld = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (bus.io_out_valid !== 1'b0 || bus.io_in_ready[0] !== 1'b0 || bus.io_locked !== 1'b1 || bus.io_chosen !== PW'(2)) begin
        n_fail++;
        $display("FAIL drop_gap %0d got valid=%b ready=%b locked=%b chosen=%0d exp 0 xxx0 1 2", k, bus.io_out_valid, bus.io_in_ready, bus.io_locked, bus.io_chosen);
      end
      adv();
    end
    vld = 4'b0101;
    lst = 4'b0100;
    #1;
    n_checks++;
    if (bus.io_out_valid !== 1'b1 || bus.io_chosen !== PW'(2)) begin
      n_fail++;
      $display("FAIL drop_resume got valid=%b chosen=%0d exp 1 2", bus.io_out_valid, bus.io_chosen);
    end
    adv();
    #1;
    n_checks++;
    if (bus.io_locked !== 1'b0 || bus.io_chosen !== PW'(0)) begin
      n_fail++;
      $display("FAIL drop_after got locked=%b chosen=%0d exp 0 0", bus.io_locked, bus.io_chosen);
    end
  endtask

  task automatic test_stall();
    vld = 4'b1111;
    lst = 4'b1111;
    rdy = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (bus.io_chosen !== PW'(3) || bus.io_in_ready !== '0 || bus.io_locked !== 1'b0) begin
        n_fail++;
        $display("FAIL stall %0d got chosen=%0d ready=%b locked=%b exp 3 0000 0", k, bus.io_chosen, bus.io_in_ready, bus.io_locked);
      end
      adv();
    end
  endtask

  task automatic test_reset_locked();
    vld = 4'b1111;
    lst = 4'b0000;
    rdy = 1;
    adv();
    #1;
    n_checks++;
    if (bus.io_locked !== 1'b1 || bus.io_chosen !== PW'(3)) begin
      n_fail++;
      $display("FAIL lock_req3 got locked=%b chosen=%0d exp 1 3", bus.io_locked, bus.io_chosen);
    end
    reset = 1;
    adv();
    reset = 0;
    #1;
    n_checks++;
    if (bus.io_locked !== 1'b0 || bus.io_chosen !== PW'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_packet got locked=%b chosen=%0d exp 0 0", bus.io_locked, bus.io_chosen);
    end
    adv();
  endtask

`ifdef RR_ARB_GRANT_STATS_EN
  task automatic test_stats();
    reset = 1;
    adv();
    reset = 0;
    rdy = 1;
    vld = 4'b0010;
    lst = 4'b0010;
    repeat (5) adv();
    vld = 4'b1000;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 3; b++) begin
        lst = (b == 2) ? 4'b1000 : 4'b0000;
        adv();
      end
    vld = '0;
    #1;
    n_checks++;
    if (bus.io_pkt_count[16 +: 16] !== 16'd5 || bus.io_pkt_count[48 +: 16] !== 16'd2 || bus.io_pkt_count[0 +: 16] !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_counts got %h exp slice1=5 slice3=2 slice0=0", bus.io_pkt_count);
    end
    vld = 4'b0001;
    lst = 4'b0001;
    repeat (70000) adv();
    #1;
    n_checks++;
    if (bus.io_pkt_count[0 +: 16] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_saturate got %h exp ffff", bus.io_pkt_count[0 +: 16]);
    end
  endtask
`endif

  task automatic test_random();
    int c;
    logic [PW-1:0] e_ch;
    logic e_v;
    logic e_l;
    logic e_lk;
    logic [W-1:0] e_b;
    logic [N-1:0] e_r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        lst[i] = ($urandom_range(0, 2) == 0);
        bits[i * W +: W] = $urandom;
      end
      rdy = ($urandom_range(0, 3) != 0);
      c = exp_chosen();
      e_r = '0;
      if (reset) begin
        e_ch = '0;
        e_v = 0;
        e_l = 0;
        e_lk = 0;
        e_b = '0;
      end else begin
        e_ch = PW'(c);
        e_v = vld[c];
        e_l = lst[c];
        e_lk = m_locked;
        e_b = bits[c * W +: W];
        e_r[c] = rdy;
      end
      #1;
      n_checks++;
      if (bus.io_chosen !== e_ch || bus.io_out_valid !== e_v || bus.io_out_last !== e_l || bus.io_locked !== e_lk || bus.io_out_bits !== e_b || bus.io_in_ready !== e_r) begin
        n_fail++;
        $display("FAIL random cyc %0d got ch=%0d v=%b l=%b lk=%b r=%b b=%h exp ch=%0d v=%b l=%b lk=%b r=%b b=%h", cyc, bus.io_chosen, bus.io_out_valid, bus.io_out_last, bus.io_locked, bus.io_in_ready, bus.io_out_bits, e_ch, e_v, e_l, e_lk, e_r, e_b);
      end
`ifdef RR_ARB_GRANT_STATS_EN
      begin
        logic [N*16-1:0] e_cnt;
        for (int i = 0; i < N; i++) e_cnt[i * 16 +: 16] = reset ? 16'd0 : 16'(m_cnt[i]);
        n_checks++;
        if (bus.io_pkt_count !== e_cnt) begin
          n_fail++;
          $display("FAIL random_count cyc %0d got %h exp %h", cyc, bus.io_pkt_count, e_cnt);
        end
      end
`endif
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_drop();
    test_stall();
    test_reset_locked();
`ifdef RR_ARB_GRANT_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

N-input round-robin arbiter with burst locking, sharing one ready/valid output channel among requesters. It replaces the fixed-priority, single-beat arbiter wherever a downstream port receives multi-beat packets from several sources. Once a requester wins, the block holds the grant until that requester's final beat transfers, so packets never interleave. The data path is combinational, pass-through and unbuffered; only grant state is registered.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `W`, 32: payload width per beat.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_in_valid`  in  N  per-requester valid.
- `io_in_ready`  out  N  per-requester ready.
- `io_in_bits`  in  N*W  payloads; requester i occupies bits [i*W +: W].
- `io_in_last`  in  N  per-requester end-of-packet flag.
- `io_out_valid`  out  1  selected valid.
- `io_out_ready`  in  1  downstream ready.
- `io_out_bits`  out  W  selected payload.
- `io_out_last`  out  1  selected last flag.
- `io_chosen`  out  clog2(N)  index of the requester currently routed to the output.
- `io_locked`  out  1  high while a packet is in flight (state LOCKED).

## Operation
- State machine with two states, IDLE and LOCKED, plus registers `ptr` (clog2(N) bits) and `owner` (clog2(N) bits).
- IDLE: `io_chosen` is the first i with `io_in_valid[i]`=1, searching from `ptr` upward with wrap modulo N. If no input is valid, `io_chosen`=`ptr`.
- LOCKED: `io_chosen`=`owner`; valids from all other requesters are ignored.
- Datapath:
  - `io_out_valid`/`bits`/`last` = the selected requester's signals.
  - `io_in_ready[i]` = `io_out_ready` && (i == `io_chosen`); all other readies are 0.
- fire = `io_out_valid` && `io_out_ready`.
- Transitions:
  - IDLE, fire, last=0 → LOCKED; `owner` ← `io_chosen`.
  - IDLE, fire, last=1 → stay IDLE (single-beat packet); `ptr` ← `io_chosen`+1 mod N.
  - LOCKED, fire, last=1 → IDLE; `ptr` ← `owner`+1 mod N.
  - LOCKED, fire, last=0 → stay LOCKED.
  - No fire → no state change.
- In LOCKED, an owner that drops valid mid-packet keeps the lock. `io_out_valid` is 0 until the owner resumes; other requesters wait.
- Pointer wrap: `ptr`+1 when `ptr`=N-1 gives 0. When N is not a power of 2, values ≥N are never produced.
- If the winning requester deasserts valid before a handshake, the block may choose a different requester next cycle; this is legal.

## Timing
- Zero-cycle latency from input to output; no registers in the data path.
- Grant and lock decisions take effect the cycle after the fire.
- Reset values: state=IDLE, `ptr`=0, `owner`=0, `io_locked`=0.
- While `reset`=1, all outputs are forced to 0, including `io_in_ready` and `io_out_valid`.
- Reset asserted mid-packet abandons the lock. The first post-reset grant follows IDLE rules from `ptr`=0.
- The block adds no combinational path from `io_out_ready` to any `io_in_valid`.

## Configuration
- `RR_ARB_GRANT_STATS_EN` defined:
  - Adds output `io_pkt_count` (N*16 bits): one 16-bit counter per requester, slice i at [i*16 +: 16].
  - Counter i increments on each fire with last=1 while `io_chosen`=i.
  - Counters saturate at 0xFFFF and reset to 0.
- Macro undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then N=4, all valids=1, every beat last=1, `io_out_ready`=1 → `io_chosen` sequence 0,1,2,3,0 on consecutive cycles.
- Req1 sends a 3-beat packet while req0 and req2 are valid → `io_chosen`=1 for 3 fires, `io_locked`=1 after beat 1 and 0 after beat 3; next grant is 2.
- Locked on req2, req2 drops valid for 2 cycles mid-packet while req0 is valid → `io_out_valid`=0 and `io_in_ready[0]`=0 during the gap; req2 resumes and finishes the packet.
- `io_out_ready`=0 for 5 cycles with all valids=1 → no state change; `io_chosen` stays fixed; all `io_in_ready`=0.
- Reset pulsed while LOCKED on req3 → next cycle `io_locked`=0, `ptr`=0; req0 wins if valid.
- With `RR_ARB_GRANT_STATS_EN`: 5 one-beat packets from req1 and 2 three-beat packets from req3 → `io_pkt_count` slices [1]=5, [3]=2; 70000 packets from req0 → slice [0]=0xFFFF.
